// File: rtl/uart_pkg.sv
// Purpose: shared types and sizing helpers for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 104;

    // Width of a counter that must reach clks_per_bit-1.
    function automatic int baud_cnt_w(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Purpose: metastability synchronizer for the raw RX pin; resets to the idle (high) level.
// Latency: SYNC_STAGES cycles from i_rx to o_rxs.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), i_rx (async pin), o_rxs (synchronized level).
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rxs
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign o_rxs = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// Purpose: UART receiver, deframes 8N1 (8E1 with UART_RX_PARITY_EN) characters into bytes.
// Latency: rx_data_rdy / rx_frame_err pulse SYNC_STAGES+1 cycles after the stop-bit centre on the pin.
// Backpressure: none; each byte is presented for one strobe cycle and overwritten by the next.
// Ports: clk, rst_n (async active-low), rx_serial (pin, idle high), rx_data[7:0] (last good byte),
//        rx_data_rdy (1-cycle good-byte strobe), rx_frame_err (1-cycle bad-frame strobe),
//        rx_busy (start detect until back in IDLE).
// Config macro: UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int             CW      = baud_cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            w_rxs;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_rdy;
    logic            r_err;
    logic            r_busy;
`ifdef UART_RX_PARITY_EN
    logic            r_par_err;
`endif

    rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rx  (rx_serial),
        .o_rxs (w_rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle by default; set only on the frame-ending edge.
            r_rdy <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            // Line came back high before mid start bit: a glitch.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt     <= '0;
                        r_par_err <= ^{r_shift, w_rxs};
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            // Leave at stop-bit centre so a following start bit is not missed.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (r_par_err) begin
                                r_err <= 1'b1;
                            end else begin
                                r_data <= r_shift;
                                r_rdy  <= 1'b1;
                            end
`else
                            r_data <= r_shift;
                            r_rdy  <= 1'b1;
`endif
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                BREAK: begin
                    // Held-low line: one error already reported, wait for idle level.
                    if (w_rxs) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data      = r_data;
    assign rx_data_rdy  = r_rdy;
    assign rx_frame_err = r_err;
    assign rx_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Purpose: self-checking bench for uart_rx_byte using an event scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_byte;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       rx_frame_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Event encoding: {rdy, err, rx_data}
    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_data_rdy  (rx_data_rdy),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    // Every strobe cycle becomes one observed event; a two-cycle pulse shows up as two.
    always @(negedge clk) begin
        if (rx_data_rdy || rx_frame_err)
            obs_q.push_back({rx_data_rdy, rx_frame_err, rx_data});
    end

    task automatic drive_bit(input logic v);
        rx_serial = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_v);
    endtask

    task automatic expect_good(input logic [7:0] b);
        exp_q.push_back({2'b10, b});
        last_good = b;
    endtask

    task automatic expect_err();
        exp_q.push_back({2'b01, last_good});
    endtask

    // Bounded wait for n observed events, then a short settle to catch stray pulses.
    task automatic wait_obs(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) break;
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (rx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_data got=%h want=00", rx_data);
        end
        n_checks++;
        if ({rx_data_rdy, rx_frame_err, rx_busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got=%b want=000", {rx_data_rdy, rx_frame_err, rx_busy});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_basic();
        expect_good(8'h41);
        send_frame(8'h41, 1'b1);
        wait_obs(exp_q.size(), 400);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [9:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL basic_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_checks++;
        if (rx_data !== 8'h41) begin n_fail++; $display("FAIL basic_hold got=%h want=41", rx_data); end
    endtask

    task automatic test_glitch();
        rx_serial = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise got=%b want=1", rx_busy); end
        repeat (20) @(negedge clk);
        rx_serial = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall got=%b want=0", rx_busy); end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_strobe got=%0d want=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_frame_err();
        expect_err();
        send_frame(8'h53, 1'b0);
        wait_obs(exp_q.size(), 400);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ferr_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [9:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL ferr_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        // Line is still low from the bad stop bit; keep it there.
        repeat (2000) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL break_strobe got=%0d want=0", obs_q.size()); end
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL break_busy got=%b want=1", rx_busy); end
        obs_q.delete();
        rx_serial = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_release got=%b want=0", rx_busy); end
        expect_good(8'h0D);
        send_frame(8'h0D, 1'b1);
        wait_obs(exp_q.size(), 400);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL after_break_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [9:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL after_break_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h40; seq[1] = 8'h0D; seq[2] = 8'h4E;
        for (int i = 0; i < 3; i++) begin
            expect_good(seq[i]);
            send_frame(seq[i], 1'b1);
        end
        wait_obs(exp_q.size(), 400);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [9:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'h35;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx_serial = b[4];
        repeat (CPB / 2) @(negedge clk);
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy got=%b want=1", rx_busy); end
        rst_n = 1'b0;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_data, rx_data_rdy, rx_frame_err, rx_busy} !== 11'h000) begin
            n_fail++;
            $display("FAIL midframe_reset got=%h/%b%b%b want=00/000", rx_data, rx_data_rdy, rx_frame_err, rx_busy);
        end
        rst_n = 1'b1;
        last_good = 8'h00;
        repeat (3 * CPB) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL midframe_strobe got=%0d want=0", obs_q.size()); end
        obs_q.delete();
        expect_good(8'h31);
        send_frame(8'h31, 1'b1);
        wait_obs(exp_q.size(), 400);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL post_reset_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [9:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL post_reset_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        b = 8'h41;
        expect_good(b);
        send_frame(b, 1'b1);
        // Same byte with the parity bit inverted.
        expect_err();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(~(^b));
        drive_bit(1'b1);
        wait_obs(exp_q.size(), 400);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL parity_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [9:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL parity_event got=%h want=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL parity_idle got=%b want=0", rx_busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
